// File: rtl/uart_receive_if.sv
// uart_receive_if: bundles the serial input, the consumer handshake and the
// status pulses of the uart_receive block.
//   master : the side that drives the line and acknowledges data
//   slave  : the receiver itself
interface uart_receive_if #(
    parameter int D_WIDTH = 15
);
    logic               rx;
    logic               rx_ack;
    logic [D_WIDTH-1:0] rx_data;
    logic               rx_valid;
    logic               rx_busy;
    logic               frame_err;
    logic               overrun;

    modport master (
        output rx,
        output rx_ack,
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  rx,
        input  rx_ack,
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/uart_receive.sv
// uart_receive: single-sample-per-cycle UART frame receiver.
// Frame: start bit 0, D_WIDTH data bits LSB first, stop bit 1; idle line is 1.
// A stop bit sampled 0 reports frame_err and parks the receiver in BREAK
// until the line returns high. Received payloads are held in rx_data with
// rx_valid until acknowledged; overwriting an unacknowledged payload pulses
// overrun.
// Optional feature: define UART_RECEIVE_SYNC_EN to pass rx through a
// two-flop synchronizer (both flops reset to 1); this delays every sample
// point by two cycles.
module uart_receive #(
    parameter int D_WIDTH = 15
) (
    input  logic           clk,
    input  logic           rst,
    uart_receive_if.slave  bus
);

    // Counter must be able to hold D_WIDTH without wrapping.
    localparam int CNT_W = $clog2(D_WIDTH + 1);
    // Index width into the shift register (at least one bit).
    localparam int IDX_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(D_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STOP  = 2'd2,
        BREAK = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [D_WIDTH-1:0] shift_q, shift_d;
    logic [D_WIDTH-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_busy_q, rx_busy_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;

    // Line value seen by the FSM (either raw or synchronized).
    logic               rx_s;
    // Bit position within the payload for the current data sample.
    logic [IDX_W-1:0]   idx_s;

`ifdef UART_RECEIVE_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer; resets to the idle level so no false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;
`else
    assign rx_s = bus.rx;
`endif

    assign idx_s = cnt_q[IDX_W-1:0];

    // Next-state, datapath and output-pulse logic of the receive FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consumer acknowledge only has effect while data is pending.
        if (rx_valid_q && bus.rx_ack) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (rx_s == 1'b0) begin
                    state_d = DATA;
                    cnt_d   = {CNT_W{1'b0}};
                    shift_d = {D_WIDTH{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end

            DATA: begin
                // Writing by position keeps bit 0 = first received bit.
                shift_d[idx_s] = rx_s;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = STOP;
                end else begin
                    state_d = DATA;
                end
            end

            STOP: begin
                if (rx_s == 1'b1) begin
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                    // An ack on this same edge consumes the old payload first.
                    overrun_d  = rx_valid_q && !bus.rx_ack;
                    state_d    = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = BREAK;
                end
            end

            BREAK: begin
                if (rx_s == 1'b1) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Busy is registered from the next state so it tracks state_q.
        if (state_d != IDLE) begin
            rx_busy_d = 1'b1;
        end else begin
            rx_busy_d = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            shift_q     <= {D_WIDTH{1'b0}};
            rx_data_q   <= {D_WIDTH{1'b0}};
            rx_valid_q  <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_busy   = rx_busy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: randomized and directed frames checked cycle by cycle
// against a frame-level reference model.
module tb_uart_receive;

    localparam int DW = 15;
`ifdef UART_RECEIVE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_receive_if #(.D_WIDTH(DW)) bus ();

    uart_receive #(.D_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-sample expectations (index = position in the line bit stream).
    bit            rx_s_q[$];
    bit            load_q[$];
    logic [DW-1:0] ldata_q[$];
    bit            ferr_q[$];
    bit            busy_q[$];

    task automatic push_sample(input bit r, input bit ld, input logic [DW-1:0] d,
                               input bit fe, input bit bz);
        rx_s_q.push_back(r);
        load_q.push_back(ld);
        ldata_q.push_back(d);
        ferr_q.push_back(fe);
        busy_q.push_back(bz);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) push_sample(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // One frame; a bad stop is followed by 'zeros' more low samples and one high.
    task automatic add_frame(input logic [DW-1:0] d, input bit good, input int zeros,
                             output int stop_idx);
        push_sample(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DW; i++) push_sample(d[i], 1'b0, '0, 1'b0, 1'b1);
        stop_idx = rx_s_q.size();
        push_sample(good, good, d, !good, !good);
        if (!good) begin
            for (int i = 0; i < zeros; i++) push_sample(1'b0, 1'b0, '0, 1'b0, 1'b1);
            push_sample(1'b1, 1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"},  32'(bus.rx_data),   32'd0);
        check_eq({tag, "_valid"}, 32'(bus.rx_valid),  32'd0);
        check_eq({tag, "_busy"},  32'(bus.rx_busy),   32'd0);
        check_eq({tag, "_ferr"},  32'(bus.frame_err), 32'd0);
        check_eq({tag, "_ovr"},   32'(bus.overrun),   32'd0);
    endtask

    int            st_2a5b, st_0001, st_7fff, st_1234, st_0abc, st_3c3c, tmp;
    int            rand_from, n_smp, n_cyc;
    bit            ack_c[];
    bit            m_valid, m_ovr, m_ferr, m_busy, ld;
    logic [DW-1:0] m_data;
    logic [DW-1:0] d5555, d0f0f;

    initial begin
        rst        = 1'b1;
        bus.rx     = 1'b1;
        bus.rx_ack = 1'b0;
        #1;
        check_all_zero("reset");

        // ---------------- build the stimulus stream ----------------
        add_idle(2);
        add_frame(15'h2A5B, 1'b1, 0, st_2a5b);
        add_idle(3);
        add_frame(15'h0001, 1'b1, 0, st_0001);
        add_frame(15'h7FFF, 1'b1, 0, st_7fff);
        add_idle(3);
        add_frame(15'h1234, 1'b0, 5, st_1234);
        add_idle(2);
        add_frame(15'h0ABC, 1'b1, 0, st_0abc);
        add_idle(2);
        add_frame(15'h3C3C, 1'b1, 0, st_3c3c);
        add_idle(2);
        rand_from = rx_s_q.size();
        for (int f = 0; f < 24; f++) begin
            add_frame(DW'($urandom), ($urandom_range(0, 5) != 0), $urandom_range(0, 5), tmp);
            add_idle($urandom_range(0, 3));
        end
        add_idle(2);

        n_smp = rx_s_q.size();
        n_cyc = n_smp + LAT;
        ack_c = new[n_cyc];
        for (int c = 0; c < n_cyc; c++) ack_c[c] = 1'b0;
        ack_c[st_2a5b + LAT + 2] = 1'b1;   // consume 2A5B before 0001 arrives? no: 2 cycles later
        ack_c[st_7fff + LAT + 2] = 1'b1;   // clear before the bad-stop frame
        ack_c[st_3c3c + LAT]     = 1'b1;   // ack on the same edge as the 3C3C stop
        for (int c = rand_from + LAT; c < n_cyc; c++) ack_c[c] = ($urandom_range(0, 3) == 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- cycle-by-cycle run with reference model ----------------
        m_valid = 1'b0;
        m_data  = '0;
        for (int c = 0; c < n_cyc; c++) begin
            int s;
            @(negedge clk);
            bus.rx     = (c < n_smp) ? rx_s_q[c] : 1'b1;
            bus.rx_ack = ack_c[c];
            @(posedge clk);
            #1;
            s      = c - LAT;
            ld     = (s >= 0) && load_q[s];
            m_ovr  = ld && m_valid && !ack_c[c];
            if (m_valid && ack_c[c]) m_valid = 1'b0;
            if (ld) begin
                m_valid = 1'b1;
                m_data  = ldata_q[s];
            end
            m_ferr = (s >= 0) && ferr_q[s];
            m_busy = (s >= 0) && busy_q[s];

            check_eq("rx_valid",  32'(bus.rx_valid),  32'(m_valid));
            check_eq("rx_data",   32'(bus.rx_data),   32'(m_data));
            check_eq("overrun",   32'(bus.overrun),   32'(m_ovr));
            check_eq("frame_err", 32'(bus.frame_err), 32'(m_ferr));
            check_eq("rx_busy",   32'(bus.rx_busy),   32'(m_busy));

            if (c == st_2a5b + LAT - 1) check_eq("f2a5b_valid_before", 32'(bus.rx_valid), 32'd0);
            if (c == st_2a5b + LAT) begin
                check_eq("f2a5b_valid", 32'(bus.rx_valid), 32'd1);
                check_eq("f2a5b_data",  32'(bus.rx_data),  32'h2A5B);
                check_eq("f2a5b_ferr",  32'(bus.frame_err), 32'd0);
            end
            if (c == st_7fff + LAT) begin
                check_eq("b2b_overrun", 32'(bus.overrun),  32'd1);
                check_eq("b2b_data",    32'(bus.rx_data),  32'h7FFF);
                check_eq("b2b_valid",   32'(bus.rx_valid), 32'd1);
            end
            if (c == st_7fff + LAT + 1) check_eq("b2b_overrun_pulse", 32'(bus.overrun), 32'd0);
            if (c == st_1234 + LAT) begin
                check_eq("bad_stop_ferr",  32'(bus.frame_err), 32'd1);
                check_eq("bad_stop_valid", 32'(bus.rx_valid),  32'd0);
            end
            if (c == st_1234 + LAT + 1) check_eq("bad_stop_ferr_pulse", 32'(bus.frame_err), 32'd0);
            if (c == st_3c3c + LAT) begin
                check_eq("ack_same_valid", 32'(bus.rx_valid), 32'd1);
                check_eq("ack_same_data",  32'(bus.rx_data),  32'h3C3C);
                check_eq("ack_same_ovr",   32'(bus.overrun),  32'd0);
            end
        end

        // ---------------- reset in the middle of a frame ----------------
        d5555 = 15'h5555;
        d0f0f = 15'h0F0F;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        bus.rx     = 1'b0;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            bus.rx = d5555[i];
        end
        @(negedge clk);
        rst    = 1'b1;
        bus.rx = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            bus.rx = 1'b1;
        end
        @(negedge clk);
        bus.rx = 1'b0;
        for (int i = 0; i < DW; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_frame_ferr", 32'(bus.frame_err), 32'd0);
            @(negedge clk);
            bus.rx = d0f0f[i];
        end
        @(negedge clk);
        bus.rx = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < LAT; k++) begin
            check_eq("rst_frame_wait_valid", 32'(bus.rx_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check_eq("rst_frame_valid", 32'(bus.rx_valid),  32'd1);
        check_eq("rst_frame_data",  32'(bus.rx_data),   32'h0F0F);
        check_eq("rst_frame_ferr2", 32'(bus.frame_err), 32'd0);
        check_eq("rst_frame_ovr",   32'(bus.overrun),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receive.md
UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 SHALL have parameter D_WIDTH, default 15, data bits per frame (legal 1..30).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx  input  1  serial line; idle 1; one bit per clk cycle.
REQ-005 SHALL have port rx_ack  input  1  consumer acknowledge of rx_data.
REQ-006 SHALL have port rx_data  output  D_WIDTH  last good frame payload, bit 0 = first received data bit.
REQ-007 SHALL have port rx_valid  output  1  rx_data holds unconsumed frame.
REQ-008 SHALL have port rx_busy  output  1  frame reception in progress (state not IDLE).
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled 0.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: unacked frame overwritten.

Function
REQ-011 Frame format SHALL be: start bit 0, D_WIDTH data bits LSB first, stop bit 1; extra 1s = idle.
REQ-012 FSM SHALL have states IDLE, DATA, STOP, BREAK; one rx sample per cycle, no oversampling.
REQ-013 IDLE: rx==0 sampled at edge T -> DATA, bit counter cleared; rx==1 -> stay IDLE.
REQ-014 DATA: data bit i SHALL be sampled at edge T+1+i, shifted into a D_WIDTH shift register; after bit D_WIDTH-1 -> STOP.
REQ-015 Bit counter SHALL be ceil(log2(D_WIDTH+1)) bits wide and never wrap within a frame.
REQ-016 STOP at edge T+1+D_WIDTH, rx==1: rx_data <= shift register, rx_valid <= 1, -> IDLE; next start detectable at edge T+2+D_WIDTH.
REQ-017 STOP, rx==0: frame_err pulses 1 cycle, payload discarded, rx_data/rx_valid unchanged, -> BREAK.
REQ-018 BREAK: stay until rx==1 sampled, then -> IDLE; no start detection while in BREAK.
REQ-019 rx_valid && rx_ack at an edge SHALL clear rx_valid after that edge; rx_ack with rx_valid==0 SHALL be ignored.
REQ-020 Good stop while rx_valid==1 and no rx_ack same edge: rx_data overwritten, rx_valid stays 1, overrun pulses 1 cycle.
REQ-021 Good stop with rx_ack same edge: new data loaded, rx_valid stays 1, no overrun.
REQ-022 rx_busy SHALL be 1 in DATA, STOP, BREAK; 0 in IDLE.
REQ-023 All outputs SHALL be registered; no combinational path from rx or rx_ack to outputs.

Reset
REQ-024 rst==1 SHALL immediately force IDLE, counter 0, shift register 0, rx_data 0, rx_valid 0, rx_busy 0, frame_err 0, overrun 0.
REQ-025 Reset mid-frame SHALL discard partial frame; after release, first rx==0 sample starts a new frame.

Configuration
REQ-026 Macro UART_RECEIVE_SYNC_EN defined: rx SHALL pass through a two-flop synchronizer (both flops reset to 1) before the FSM; all sample edges in REQ-013..REQ-018 shift +2 cycles.
REQ-027 UART_RECEIVE_SYNC_EN undefined: rx SHALL feed the FSM directly with timing exactly as stated.

Verification (D_WIDTH=15, macro undefined unless stated)
REQ-028 Send 0 + 15'h2A5B LSB first + 1 -> rx_data==15'h2A5B, rx_valid rises cycle after stop sample, frame_err 0.
REQ-029 Two back-to-back frames 15'h0001, 15'h7FFF, no ack -> second load gives overrun 1-cycle pulse, rx_data==15'h7FFF, rx_valid 1.
REQ-030 Frame 15'h1234 with stop bit 0, rx held 0 five more cycles, then 1 -> frame_err one pulse, rx_valid stays 0, no new frame until rx returns 1.
REQ-031 Assert rst at data bit 7 of 15'h5555, release, send 15'h0F0F -> outputs 0 during reset, then rx_data==15'h0F0F, no frame_err.
REQ-032 rx_ack on same edge as good stop of 15'h3C3C with prior valid data -> rx_valid stays 1, rx_data==15'h3C3C, overrun 0.
REQ-033 UART_RECEIVE_SYNC_EN defined, send 15'h2A5B -> same data, rx_valid 2 cycles later than REQ-028.
